// File: rtl/shader_indicator.sv
// ============================================================================
// Module      : shader_indicator
// Description : Blinks an active-low LED (index+1) times per pattern for the
//               selected shader code, followed by a dark gap, then repeats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shader_indicator #(
  parameter int unsigned ON_CYCLES  = 3750000,
  parameter int unsigned OFF_CYCLES = 3750000,
  parameter int unsigned GAP_CYCLES = 15000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] shader_select,
  output logic       led_n,
  output logic [2:0] shader_index,
  output logic       index_valid,
  output logic       pattern_start
);

  localparam int unsigned c_MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned c_MAX_N      = (c_MAX_ON_OFF > GAP_CYCLES) ? c_MAX_ON_OFF : GAP_CYCLES;
  localparam int          c_TW_RAW     = $clog2(c_MAX_N + 1);
  localparam int          TW           = (c_TW_RAW < 26) ? 26 : c_TW_RAW;

  localparam logic [TW-1:0] c_ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] c_OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] c_GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        r_state, w_state;
  logic [3:0]    r_sel;
  logic [TW-1:0] r_timer, w_timer;
  logic [2:0]    r_remaining, w_remaining;
  logic [2:0]    r_index, w_index;
  logic          r_valid, w_valid;
  logic          r_start, w_start;

  logic          w_change;
  logic          w_code_ok;
  logic [2:0]    w_code_idx;

  always_comb begin
    w_code_ok  = 1'b1;
    w_code_idx = 3'd0;
    case (shader_select)
      4'd6:    w_code_idx = 3'd0;
      4'd3:    w_code_idx = 3'd1;
      4'd7:    w_code_idx = 3'd2;
      4'd8:    w_code_idx = 3'd3;
      4'd4:    w_code_idx = 3'd4;
      4'd2:    w_code_idx = 3'd5;
      default: w_code_ok  = 1'b0;
    endcase
  end

  assign w_change = (shader_select != r_sel);

  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_remaining = r_remaining;
    w_index     = r_index;
    w_valid     = r_valid;
    w_start     = 1'b0;
    // A code change overrides any timer-driven transition.
    if (w_change) begin
      w_timer = '0;
      if (w_code_ok) begin
        w_state     = S_ON;
        w_index     = w_code_idx;
        w_valid     = 1'b1;
        w_remaining = w_code_idx;
        w_start     = 1'b1;
      end else begin
        w_state = S_IDLE;
        w_valid = 1'b0;
      end
    end else begin
      case (r_state)
        S_ON: begin
          if (r_timer == c_ON_LAST) begin
            w_state = S_OFF;
            w_timer = '0;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
        S_OFF: begin
          if (r_timer == c_OFF_LAST) begin
            w_timer = '0;
            if (r_remaining != 3'd0) begin
              w_state     = S_ON;
              w_remaining = r_remaining - 3'd1;
            end else begin
              w_state = S_GAP;
            end
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
        S_GAP: begin
          if (r_timer == c_GAP_LAST) begin
            w_state     = S_ON;
            w_timer     = '0;
            w_remaining = r_index;
            w_start     = 1'b1;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
        default: w_timer = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 4'd0;
      r_timer     <= '0;
      r_remaining <= 3'd0;
      r_index     <= 3'd0;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sel       <= shader_select;
      r_timer     <= w_timer;
      r_remaining <= w_remaining;
      r_index     <= w_index;
      r_valid     <= w_valid;
      r_start     <= w_start;
    end
  end

  assign led_n         = (r_state != S_ON);
  assign shader_index  = r_index;
  assign index_valid   = r_valid;
  assign pattern_start = r_start;

endmodule

`default_nettype wire
